// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and receiver state encoding for the PS/2 key receiver
// Purpose: prefix byte values, pause-sequence length and receiver FSM states.
// Ports: none (package).
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    // The pause key sends E1 followed by seven more bytes that carry no event.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser plus stability filter for one raw PS/2 line
// Purpose: brings an asynchronous PS/2 pin into the clock domain and rejects
//          glitches shorter than FILTER_LEN samples.
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset (output returns to 1, the idle level)
//   i_line  - raw asynchronous line
//   o_line  - filtered line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_line
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_out;
    logic [CW-1:0] r_cnt;

    // The counter tracks how many consecutive samples disagree with the
    // current output; any agreeing sample restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_out   <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_out <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_line = r_out;

endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - host-side PS/2 keyboard receiver producing an 11-bit key event word
// Purpose: deserialises device-to-host PS/2 frames and folds E0/F0/E1 prefixes
//          into a toggle-flagged key event.
// Ports:
//   i_clk_sys     - system clock
//   i_reset       - synchronous active-high reset
//   i_ps2_clk     - raw PS/2 clock pin (asynchronous)
//   i_ps2_data    - raw PS/2 data pin (asynchronous)
//   o_ps2_key     - {toggle, pressed, extended, scancode[7:0]}
//   o_frame_err   - one-cycle pulse when a frame is discarded
//   o_busy        - high while a frame is being received
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    output logic [10:0] o_ps2_key,
    output logic        o_frame_err,
    output logic        o_busy
);

    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic            w_clk_f;
    logic            w_data_f;
    logic            w_fall;
    logic            w_timeout;
    logic            w_valid;
    logic            w_err;
    logic            w_shift;
    logic            w_cap_par;
    logic            w_start;

    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic            r_clk_prev;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TW-1:0]   r_to_cnt;
    logic            r_byte_vld;
    logic [7:0]      r_byte;
    logic            r_ext_pend;
    logic            r_rel_pend;
    logic [2:0]      r_skip_cnt;
    logic [10:0]     r_ps2_key;
    logic            r_frame_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_line  (i_ps2_clk),
        .o_line  (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_line  (i_ps2_data),
        .o_line  (w_data_f)
    );

    assign w_fall = r_clk_prev & ~w_clk_f;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timeout takes priority: it can only fire in a cycle with no strobe.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_cap_par    = 1'b0;
        w_valid      = 1'b0;
        w_err        = 1'b0;
        w_timeout    = (r_state != IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_state_next = IDLE;
            w_err        = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_data_f) begin
                        w_state_next = DATA;
                        w_start      = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                DATA: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_cap_par    = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    if (w_data_f && parity_ok(r_shift, r_parity)) begin
                        w_valid = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_clk_prev  <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_vld  <= 1'b0;
            r_byte      <= 8'h00;
            r_ext_pend  <= 1'b0;
            r_rel_pend  <= 1'b0;
            r_skip_cnt  <= 3'd0;
            r_ps2_key   <= 11'h000;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_prev  <= w_clk_f;
            r_frame_err <= w_err;
            r_byte_vld  <= w_valid;
            if (w_valid) begin
                r_byte <= r_shift;
            end

            if (r_state == IDLE || w_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_start) begin
                r_bit_cnt <= 3'd0;
            end
            if (w_shift) begin
                r_shift   <= {w_data_f, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_cap_par) begin
                r_parity <= w_data_f;
            end

            // A discarded frame drops any prefix state so it cannot attach
            // to the next good key.
            if (w_err) begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
                r_skip_cnt <= 3'd0;
            end else if (r_byte_vld) begin
                if (r_skip_cnt != 3'd0) begin
                    r_skip_cnt <= r_skip_cnt - 3'd1;
                end else if (r_byte == PS2_PAUSE) begin
                    r_skip_cnt <= PAUSE_TAIL;
                end else if (r_byte == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_byte == PS2_REL) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    r_ps2_key  <= {~r_ps2_key[10], ~r_rel_pend, r_ext_pend, r_byte};
                    r_ext_pend <= 1'b0;
                    r_rel_pend <= 1'b0;
                end
            end
        end
    end

    assign o_ps2_key   = r_ps2_key;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Host-side PS/2 keyboard receiver. Deserialises device-to-host frames from the physical PS/2 clock and data lines.
- Folds the E0, F0 and E1 prefixes into the 11-bit ps2_key event word. The keyboard matrix block consumes this word.
- Sits between the board PS/2 pins and the keyboard matrix, in the clk_sys domain.

Parameters:
- FILTER_LEN, 8: number of consecutive equal clk_sys samples needed before a filtered PS/2 line changes state.
- TIMEOUT_CYCLES, 2000: clk_sys cycles allowed with no filtered ps2_clk falling edge, mid-frame, before the frame is aborted.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin. Asynchronous.
- ps2_data  in  1  raw PS/2 data pin. Asynchronous.
- ps2_key  out  11  event word:
  - [10] toggles once per event.
  - [9] is 1 = pressed, 0 = released.
  - [8] is 1 = extended (E0).
  - [7:0] is the scancode.
- frame_err  out  1  one-cycle pulse on a discarded frame.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- One clock, clk_sys. Reset is synchronous and active-high. Every register is updated only on the rising edge of clk_sys.
- Reset values:
  - ps2_key = 11'h000, frame_err = 0, busy = 0.
  - State = IDLE.
  - ext_pend = 0, rel_pend = 0, skip_cnt = 0, timeout counter = 0.
  - Both filtered lines = 1.
- Input conditioning, per line:
  - 2-flop synchroniser, then a stability counter.
  - The filtered output takes the synchronised value only after FILTER_LEN consecutive identical samples.
- Falling edge: a filtered ps2_clk transition 1->0, detected as a one-cycle strobe. Filtered ps2_data is sampled on that strobe.
- State machine, advancing only on the falling-edge strobe:
  - IDLE: data = 0 -> DATA with bit_cnt = 0. Data = 1 -> stay in IDLE, frame_err = 1.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: -> IDLE. Valid when stop = 1 and (^byte ^ parity) = 1 (odd parity). Otherwise frame_err = 1 and the byte is discarded.
- Timeout:
  - The counter runs in any state other than IDLE and is cleared on every strobe.
  - Reaching TIMEOUT_CYCLES -> IDLE, frame_err = 1, partial byte discarded.
- Valid-byte processing takes effect in the cycle after the STOP strobe, so ps2_key changes 1 clk_sys cycle after the stop-bit strobe. Evaluated in this order:
  1. skip_cnt != 0: decrement; no event.
  2. Byte E1: skip_cnt = 7 (swallows the pause sequence); no event.
  3. Byte E0: ext_pend = 1; no event.
  4. Byte F0: rel_pend = 1; no event.
  5. Any other byte:
     - ps2_key <= {~ps2_key[10], ~rel_pend, ext_pend, byte}.
     - Clear ext_pend and rel_pend.
- Any frame error or timeout clears ext_pend, rel_pend and skip_cnt, so no stale prefix leaks into the next event.
- ps2_key holds its value between events. Consumers detect new events by a change in bit 10.
- Reset asserted mid-frame: everything returns to reset values on that edge. The remainder of the frame on the wire is received as garbage, rejected by the framing check, and produces frame_err.
- Frame error and a valid completion never coincide; at most one outcome per frame.

Decomposition:
- Shared package ps2_pkg holds:
  - localparams PS2_EXT = 8'hE0, PS2_REL = 8'hF0, PS2_PAUSE = 8'hE1, PAUSE_TAIL = 3'd7.
  - Receiver state encodings: IDLE, DATA, PARITY, STOP.
- One sub-module, ps2_line_filter (synchroniser plus stability counter, parameter FILTER_LEN). It is instantiated twice, for clock and data.

Test Plan:
- Bench parameters: FILTER_LEN = 4, TIMEOUT_CYCLES = 400, PS/2 bit period 40 clk_sys. The bench starts with ps2_key = 0.
- Frame 0x1C with parity 0 -> ps2_key = 11'h61C (bit 10 = 1, pressed). frame_err stays 0. busy is low after stop.
- Frames E0, 75 -> ps2_key = 11'h375 (bit 10 = 0, pressed, extended). Then frames E0, F0, 75 -> 11'h575 (bit 10 = 1, released, extended).
- Frame 0x1C with parity 1 -> one-cycle frame_err and ps2_key unchanged. A following F0, 1C -> 11'h01C (released, toggled).
- Pause sequence E1 14 77 E1 F0 14 F0 77, then frame 0x1C -> exactly one new event, 0x1C pressed with bit 10 toggled. No event is produced during the pause sequence.
- Send E0 plus a start bit and 3 data bits, then idle for 500 cycles -> frame_err pulse at the timeout. The next frame 0x1C -> pressed, bit 8 = 0 (the prefix was cleared).
- A 2-cycle glitch low on ps2_clk while IDLE -> no state change and no frame_err. Reset asserted mid-frame -> all outputs zero on the next edge.
